mem_copy_arbiter: RTL

- Sits directly upstream of the data memory and owns its single address/data port.
- Muxes CPU load/store traffic with a byte-copy engine that moves len bytes from src to dst with no CPU involvement.
- CPU always has priority; the engine stalls in place while the CPU uses the port.
- Output port drives the memory's addr/data_to_write/read_enabled/write_enabled; memory reads are combinational, writes take effect at the clock edge.

---
 rtl/mem_pkg.sv | 14 +
 rtl/copy_engine.sv | 95 +++++++++
 rtl/mem_copy_arbiter.sv | 72 +++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory and its copy arbiter.
package mem_pkg;

    localparam int W_DEF = 8;
    localparam int A_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } cp_state_t;

endpackage

// File: rtl/copy_engine.sv
// Byte-copy engine: moves len bytes src->dst, one read and one write per byte.
// Holds in place whenever the memory port is taken by the CPU (stall).
module copy_engine
    import mem_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int A = A_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         cp_start,
    input  logic [A-1:0] cp_src,
    input  logic [A-1:0] cp_dst,
    input  logic [A-1:0] cp_len,
    output logic         cp_busy,
    output logic         cp_done,
    output logic [A-1:0] eng_addr,
    output logic [W-1:0] eng_wdata,
    output logic         eng_re,
    output logic         eng_we,
    input  logic [W-1:0] eng_rdata
);

    cp_state_t    state, state_next;
    logic [A-1:0] src_ptr, dst_ptr, remaining;
    logic [W-1:0] data_buf;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and port outputs; stall freezes READ/WRITE in place.
    always_comb begin
        state_next = state;
        eng_addr   = '0;
        eng_wdata  = '0;
        eng_re     = 1'b0;
        eng_we     = 1'b0;
        cp_busy    = 1'b0;
        cp_done    = 1'b0;
        case (state)
            IDLE: begin
                if (cp_start) state_next = (cp_len != '0) ? READ : DONE;
            end
            READ: begin
                eng_addr = src_ptr;
                eng_re   = 1'b1;
                cp_busy  = 1'b1;
                if (!stall) state_next = WRITE;
            end
            WRITE: begin
                eng_addr  = dst_ptr;
                eng_wdata = data_buf;
                eng_we    = 1'b1;
                cp_busy   = 1'b1;
                if (!stall) state_next = (remaining == A'(1)) ? DONE : READ;
            end
            DONE: begin
                cp_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pointers, byte count and the staging byte between read and write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            data_buf  <= '0;
        end else begin
            case (state)
                IDLE: if (cp_start) begin
                    src_ptr   <= cp_src;
                    dst_ptr   <= cp_dst;
                    remaining <= cp_len;
                end
                READ: if (!stall) data_buf <= eng_rdata;
                WRITE: if (!stall) begin
                    // Pointers wrap naturally at 2**A.
                    src_ptr   <= src_ptr + A'(1);
                    dst_ptr   <= dst_ptr + A'(1);
                    remaining <= remaining - A'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_copy_arbiter.sv
// Owns the single data-memory port; CPU traffic always wins over the copy engine.
module mem_copy_arbiter
    import mem_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int A = A_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [A-1:0] cpu_addr,
    input  logic [W-1:0] cpu_wdata,
    input  logic         cpu_re,
    input  logic         cpu_we,
    output logic [W-1:0] cpu_rdata,
    input  logic         cp_start,
    input  logic [A-1:0] cp_src,
    input  logic [A-1:0] cp_dst,
    input  logic [A-1:0] cp_len,
    output logic         cp_busy,
    output logic         cp_done,
    output logic [A-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    output logic         mem_re,
    output logic         mem_we,
    input  logic [W-1:0] mem_rdata
);

    logic         cpu_req;
    logic [A-1:0] eng_addr;
    logic [W-1:0] eng_wdata;
    logic         eng_re, eng_we;

    assign cpu_req = cpu_re | cpu_we;

    copy_engine #(.W(W), .A(A)) u_engine (
        .clk       (clk),
        .reset     (reset),
        .stall     (cpu_req),
        .cp_start  (cp_start),
        .cp_src    (cp_src),
        .cp_dst    (cp_dst),
        .cp_len    (cp_len),
        .cp_busy   (cp_busy),
        .cp_done   (cp_done),
        .eng_addr  (eng_addr),
        .eng_wdata (eng_wdata),
        .eng_re    (eng_re),
        .eng_we    (eng_we),
        .eng_rdata (mem_rdata)
    );

    // Priority mux: any CPU request takes the port verbatim.
    always_comb begin
        if (cpu_req) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_re    = cpu_re;
            mem_we    = cpu_we;
        end else begin
            mem_addr  = eng_addr;
            mem_wdata = eng_wdata;
            mem_re    = eng_re;
            mem_we    = eng_we;
        end
    end

    // Load data is gated so the CPU sees zero unless it is actually loading.
    always_comb begin
        cpu_rdata = cpu_re ? mem_rdata : '0;
    end

endmodule
